// File: rtl/readout_scheduler_if.sv
// readout_scheduler_if
//   Framed word stream from the readout scheduler toward the SPI/host side.
//   master : scheduler (drives word, channel, valid, first/last; samples ready)
//   slave  : consumer  (samples the word; drives ready)
//   A word transfers on a rising clock edge where out_valid & out_ready.
interface readout_scheduler_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;

  modport master (output out_data, out_chan, out_valid, out_first, out_last,
                  input  out_ready);
  modport slave  (input  out_data, out_chan, out_valid, out_first, out_last,
                  output out_ready);
endinterface

// File: rtl/readout_scheduler.sv
// readout_scheduler
//   Post-trigger readout sequencer for NCH digitizer channels. An accepted
//   trigger is broadcast, a HOLDOFF-cycle hold-off runs, then every enabled
//   channel is read in ascending order: read request, wait for the channel's
//   RO enable, then per word SETTLE cycles of settling, present the word,
//   and strobe spi_done once the consumer takes it.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   trigger_in          trigger request (ignored while busy -> trig_dropped)
//   cfg_how_many        words per channel, latched on trigger acceptance
//   cfg_chan_mask       enabled channels, latched on trigger acceptance
//   ch_ro_enable        per-channel RO enable from the channel controllers
//   ch_data             per-channel data, channel i at [i*WIDTH +: WIDTH]
//   trigger_out         one-cycle trigger broadcast
//   read_request        one-hot (or zero) read request
//   spi_done            one-cycle per-word advance strobe
//   stream              word stream (readout_scheduler_if.master)
//   busy                high whenever not idle
//   trig_dropped        one-cycle pulse per trigger seen while busy
//   timeout_err         sticky RO-enable timeout flag
//
// Build option
//   READOUT_TIMEOUT_EN  when defined, REQ and RELEASE give up after TIMEOUT
//                       cycles, set timeout_err and move to the next channel.
//                       When undefined they wait forever and timeout_err is 0.
module readout_scheduler #(
  parameter int NCH     = 4,
  parameter int SIZE    = 12,
  parameter int WIDTH   = 12,
  parameter int HOLDOFF = 256,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trigger_in,
  input  logic [SIZE-1:0]      cfg_how_many,
  input  logic [NCH-1:0]       cfg_chan_mask,
  input  logic [NCH-1:0]       ch_ro_enable,
  input  logic [NCH*WIDTH-1:0] ch_data,
  output logic                 trigger_out,
  output logic [NCH-1:0]       read_request,
  output logic [NCH-1:0]       spi_done,
  readout_scheduler_if.master  stream,
  output logic                 busy,
  output logic                 trig_dropped,
  output logic                 timeout_err
);

  if (NCH < 1 || NCH > 16 || HOLDOFF < 1 || SETTLE < 1 || TIMEOUT < 1) begin : g_param_check
    $error("readout_scheduler: parameter out of range");
  end

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HOLD    = 4'd1;
  localparam logic [3:0] S_SELECT  = 4'd2;
  localparam logic [3:0] S_REQ     = 4'd3;
  localparam logic [3:0] S_SETTLE  = 4'd4;
  localparam logic [3:0] S_PRESENT = 4'd5;
  localparam logic [3:0] S_ACK     = 4'd6;
  localparam logic [3:0] S_RELEASE = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int SW = $clog2(SETTLE + 1);

  logic [3:0]       state;
  logic [4:0]       ptr;       // reaches NCH (<=16) to end the walk
  logic [4:0]       last_ptr;  // highest enabled channel of this event
  logic [4:0]       last_hi;
  logic [NCH-1:0]   mask_q;
  logic [SIZE-1:0]  hm_q;
  logic [SIZE-1:0]  wc;
  logic [HW-1:0]    hold_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] data_q;
  logic             first_pend;

  // Per-lane select: ptr decoded to one-hot so the current channel's enable
  // and data come out of an AND-OR mux. ptr==NCH selects nothing.
  logic [NCH-1:0]            sel;
  logic [NCH-1:0][WIDTH-1:0] lane_data;
  logic [NCH-1:0][WIDTH-1:0] lane_gated;
  logic [WIDTH-1:0]          cur_data;
  logic                      cur_en;

  assign lane_data = ch_data;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign sel[i]        = (ptr == 5'(i));
    assign lane_gated[i] = sel[i] ? lane_data[i] : '0;
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NCH; i++) cur_data = cur_data | lane_gated[i];
  end

  assign cur_en = |(ch_ro_enable & sel);

  always_comb begin
    last_hi = '0;
    for (int i = 0; i < NCH; i++) if (cfg_chan_mask[i]) last_hi = 5'(i);
  end

`ifdef READOUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          err_q;
  assign to_hit      = (to_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      last_ptr     <= '0;
      mask_q       <= '0;
      hm_q         <= '0;
      wc           <= '0;
      hold_cnt     <= '0;
      settle_cnt   <= '0;
      data_q       <= '0;
      first_pend   <= 1'b0;
      trigger_out  <= 1'b0;
      trig_dropped <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      trigger_out  <= 1'b0;
      trig_dropped <= trigger_in && (state != S_IDLE);
`ifdef READOUT_TIMEOUT_EN
      // Free-runs only while waiting on an RO-enable edge; zero elsewhere so
      // every entry into REQ/RELEASE starts a fresh window.
      if (state == S_REQ || state == S_RELEASE) to_cnt <= to_cnt + TW'(1);
      else                                      to_cnt <= '0;
`endif
      case (state)
        S_IDLE: if (trigger_in) begin
          mask_q      <= cfg_chan_mask;
          hm_q        <= cfg_how_many;
          last_ptr    <= last_hi;
          first_pend  <= 1'b1;
          trigger_out <= 1'b1;
          hold_cnt    <= HW'(HOLDOFF - 1);
          state       <= S_HOLD;
`ifdef READOUT_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
        end
        S_HOLD: if (hold_cnt == '0) begin
          ptr   <= '0;
          state <= S_SELECT;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
        S_SELECT: if (ptr >= 5'(NCH)) begin
          state <= S_DONE;
        end else if (!(|(mask_q & sel)) || hm_q == '0) begin
          ptr <= ptr + 5'd1;
        end else begin
          wc    <= hm_q;
          state <= S_REQ;
        end
        S_REQ: if (cur_en) begin
          settle_cnt <= SW'(SETTLE - 1);
          state      <= S_SETTLE;
        end
`ifdef READOUT_TIMEOUT_EN
        else if (to_hit) begin
          err_q <= 1'b1;
          ptr   <= ptr + 5'd1;
          state <= S_SELECT;
        end
`endif
        // Channel withdrew RO enable mid-word: abandon it.
        S_SETTLE: if (!cur_en) begin
          state <= S_RELEASE;
        end else if (settle_cnt == '0) begin
          data_q <= cur_data;
          state  <= S_PRESENT;
        end else begin
          settle_cnt <= settle_cnt - SW'(1);
        end
        // A word the consumer has taken is owed its done strobe, so the
        // handshake wins over a simultaneous enable drop.
        S_PRESENT: if (stream.out_ready) begin
          first_pend <= 1'b0;
          state      <= S_ACK;
        end else if (!cur_en) begin
          state <= S_RELEASE;
        end
        S_ACK: begin
          wc <= wc - SIZE'(1);
          if (wc == SIZE'(1)) begin
            state <= S_RELEASE;
          end else begin
            settle_cnt <= SW'(SETTLE - 1);
            state      <= S_SETTLE;
          end
        end
        S_RELEASE: if (!cur_en) begin
          ptr   <= ptr + 5'd1;
          state <= S_SELECT;
        end
`ifdef READOUT_TIMEOUT_EN
        else if (to_hit) begin
          err_q <= 1'b1;
          ptr   <= ptr + 5'd1;
          state <= S_SELECT;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // read_request spans REQ..ACK; it is dropped on entry to RELEASE.
  assign read_request = (state == S_REQ || state == S_SETTLE ||
                         state == S_PRESENT || state == S_ACK) ? sel : '0;
  assign spi_done     = (state == S_ACK) ? sel : '0;
  assign busy         = (state != S_IDLE);

  assign stream.out_valid = (state == S_PRESENT);
  assign stream.out_data  = data_q;
  assign stream.out_chan  = ptr[3:0];
  assign stream.out_first = (state == S_PRESENT) && first_pend;
  assign stream.out_last  = (state == S_PRESENT) && (ptr == last_ptr) && (wc == SIZE'(1));

endmodule

// File: tb/tb_readout_scheduler.sv
// tb_readout_scheduler
//   Self-checking bench for readout_scheduler. Channel controllers are
//   modelled as 1-cycle RO-enable echoes with a random ring buffer per event;
//   the expected word list is derived from mask/how_many/ring contents.
module tb_readout_scheduler;
  localparam int NCH = 4, SIZE = 12, WIDTH = 12;
  localparam int HOLDOFF = 8, SETTLE = 2, TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 trigger_in = 1'b0;
  logic [SIZE-1:0]      cfg_how_many = '0;
  logic [NCH-1:0]       cfg_chan_mask = '0;
  logic [NCH-1:0]       ch_ro_enable = '0;
  logic [NCH*WIDTH-1:0] ch_data = '0;
  logic                 trigger_out, busy, trig_dropped, timeout_err;
  logic [NCH-1:0]       read_request, spi_done;

  readout_scheduler_if #(.WIDTH(WIDTH)) stream ();

  readout_scheduler #(
    .NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH),
    .HOLDOFF(HOLDOFF), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trigger_in(trigger_in),
    .cfg_how_many(cfg_how_many), .cfg_chan_mask(cfg_chan_mask),
    .ch_ro_enable(ch_ro_enable), .ch_data(ch_data),
    .trigger_out(trigger_out), .read_request(read_request), .spi_done(spi_done),
    .stream(stream), .busy(busy), .trig_dropped(trig_dropped), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       chan;
    logic [WIDTH-1:0] data;
    logic             first;
    logic             last;
    int               cyc;
  } word_t;

  int checks = 0, errors = 0;

  // environment state
  logic [WIDTH-1:0] pat [NCH][16];
  int               addr [NCH];
  int               rdy_mode = 0;     // 0: ready high, 1: toggle, 2: random
  logic [NCH-1:0]   dead_mask = '0;   // channels that never raise RO enable

  // monitor state
  word_t          got[$];
  word_t          exp_q[$];
  int             cyc = 0, trig_cyc, first_valid_cyc, rr2_cyc, terr_cyc;
  int             n_trig_out, n_drop, n_valid, busy_cycles;
  int             n_spi [NCH];
  int             viol_onehot, viol_overlap, viol_stall;
  logic [NCH-1:0] rr_seen;
  logic           prev_stall;
  word_t          prev_w;

  // Channel controllers + consumer: sample DUT before the edge, update after.
  initial begin
    logic [NCH-1:0] rr, sd;
    logic           tro;
    stream.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      rr = read_request; sd = spi_done; tro = trigger_out;
      @(posedge clk); #1;
      if (!reset_n) begin
        ch_ro_enable = '0;
        for (int i = 0; i < NCH; i++) addr[i] = 0;
      end else begin
        ch_ro_enable = rr & ~dead_mask;
        for (int i = 0; i < NCH; i++)
          if (tro) addr[i] = 0; else if (sd[i]) addr[i] = addr[i] + 1;
      end
      for (int i = 0; i < NCH; i++) ch_data[i*WIDTH +: WIDTH] = pat[i][addr[i] % 16];
      case (rdy_mode)
        0:       stream.out_ready = 1'b1;
        1:       stream.out_ready = ~stream.out_ready;
        default: stream.out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Observer, sampling on the falling edge.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (trigger_in && trig_cyc < 0) trig_cyc = cyc;
        if (trigger_out) n_trig_out++;
        if (trig_dropped) n_drop++;
        if (busy) busy_cycles++;
        if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
        if (read_request[2] && rr2_cyc < 0) rr2_cyc = cyc;
        if ($countones(read_request) > 1) viol_onehot++;
        if ((|spi_done) && stream.out_valid) viol_overlap++;
        rr_seen = rr_seen | read_request;
        for (int i = 0; i < NCH; i++) if (spi_done[i]) n_spi[i]++;
        w.chan = stream.out_chan; w.data = stream.out_data;
        w.first = stream.out_first; w.last = stream.out_last; w.cyc = cyc;
        if (prev_stall && (!stream.out_valid || w.chan !== prev_w.chan || w.data !== prev_w.data ||
                           w.first !== prev_w.first || w.last !== prev_w.last))
          viol_stall++;
        if (stream.out_valid) begin
          n_valid++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (stream.out_ready) got.push_back(w);
        end
        prev_stall = stream.out_valid && !stream.out_ready;
        prev_w     = w;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1);
  end

  task automatic clear_mon();
    got.delete();
    trig_cyc = -1; first_valid_cyc = -1; rr2_cyc = -1; terr_cyc = -1;
    n_trig_out = 0; n_drop = 0; n_valid = 0; busy_cycles = 0;
    for (int i = 0; i < NCH; i++) n_spi[i] = 0;
    viol_onehot = 0; viol_overlap = 0; viol_stall = 0; rr_seen = '0;
  endtask

  // Reference: enabled channels ascending, how_many ring words each.
  task automatic build_model(input logic [NCH-1:0] m, input int hm);
    word_t w;
    exp_q.delete();
    for (int c = 0; c < NCH; c++)
      if (m[c])
        for (int k = 0; k < hm; k++) begin
          w.chan = 4'(c); w.data = pat[c][k]; w.first = 1'b0; w.last = 1'b0; w.cyc = 0;
          exp_q.push_back(w);
        end
    for (int k = 0; k < exp_q.size(); k++) begin
      exp_q[k].first = (k == 0);
      exp_q[k].last  = (k == exp_q.size() - 1);
    end
  endtask

  function automatic int word_mismatches();
    int bad = 0;
    if (got.size() != exp_q.size()) bad++;
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      if (got[k].chan !== exp_q[k].chan || got[k].data !== exp_q[k].data ||
          got[k].first !== exp_q[k].first || got[k].last !== exp_q[k].last)
        bad++;
    return bad;
  endfunction

  function automatic int gap_errors();
    int bad = 0;
    for (int k = 1; k < got.size(); k++)
      if (got[k].chan == got[k-1].chan && got[k].cyc - got[k-1].cyc != SETTLE + 2) bad++;
    return bad;
  endfunction

  task automatic start_event(input logic [NCH-1:0] m, input int hm, input int rmode);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 16; k++) pat[c][k] = WIDTH'($urandom);
    build_model(m, hm);
    @(posedge clk); #1;
    clear_mon();
    rdy_mode      = rmode;
    cfg_chan_mask = m;
    cfg_how_many  = SIZE'(hm);
    trigger_in    = 1'b1;
    @(posedge clk); #1;
    trigger_in    = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({trigger_out, read_request, spi_done, stream.out_valid, stream.out_data, stream.out_chan,
         stream.out_first, stream.out_last, busy, trig_dropped, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rr=%b sd=%b valid=%b data=%h, all required 0",
               busy, read_request, spi_done, stream.out_valid, stream.out_data);
    end
  endtask

  task automatic test_full_readout();
    bit ok; int bad;
    start_event(4'b1111, 3, 0);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done: busy still 1 after budget, want 0"); end
    checks++; if (got.size() !== 12) begin errors++; $display("FAIL full_count: %0d words, want 12", got.size()); end
    bad = word_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_words: %0d mismatching words, want 0", bad); end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (n_spi[c] !== 3) begin errors++; $display("FAIL full_spi_done ch%0d: %0d pulses, want 3", c, n_spi[c]); end
    end
    checks++; if (n_trig_out !== 1) begin errors++; $display("FAIL full_trigger_out: %0d pulses, want 1", n_trig_out); end
    checks++;
    if (first_valid_cyc - trig_cyc < HOLDOFF + 2 + SETTLE) begin
      errors++; $display("FAIL full_latency: %0d cycles, want >= %0d", first_valid_cyc - trig_cyc, HOLDOFF + 2 + SETTLE);
    end
    bad = gap_errors();
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_throughput: %0d word gaps not %0d cycles, want 0", bad, SETTLE + 2); end
    checks++;
    if (viol_overlap !== 0 || viol_onehot !== 0) begin
      errors++; $display("FAIL full_invariants: overlap=%0d onehot=%0d, want 0/0", viol_overlap, viol_onehot);
    end
  endtask

  task automatic test_mask_stall();
    bit ok; int bad;
    start_event(4'b0101, 2, 1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: busy still 1 after budget, want 0"); end
    bad = word_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_words: %0d mismatching of %0d, want 0", bad, got.size()); end
    checks++; if ((rr_seen & 4'b1010) !== 4'b0000) begin errors++; $display("FAIL stall_rr_masked: seen %b, want bits 1,3 clear", rr_seen); end
    checks++; if (viol_stall !== 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled, want 0", viol_stall); end
    checks++;
    if (n_spi[0] !== 2 || n_spi[1] !== 0 || n_spi[2] !== 2 || n_spi[3] !== 0) begin
      errors++; $display("FAIL stall_spi_done: %0d,%0d,%0d,%0d, want 2,0,2,0", n_spi[0], n_spi[1], n_spi[2], n_spi[3]);
    end
  endtask

  task automatic test_drop();
    bit ok, seen; int bad;
    start_event(4'b1111, 2, 0);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      seen = stream.out_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL drop_reach_present: out_valid 0 after budget, want 1"); end
    trigger_in = 1'b1;
    @(posedge clk); #1;
    trigger_in = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_done: busy still 1 after budget, want 0"); end
    checks++; if (n_drop !== 1) begin errors++; $display("FAIL drop_pulse: %0d trig_dropped pulses, want 1", n_drop); end
    checks++; if (n_trig_out !== 1) begin errors++; $display("FAIL drop_trigger_out: %0d pulses, want 1", n_trig_out); end
    bad = word_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL drop_words: %0d mismatching words, want 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int bad;
    start_event(4'b1111, 3, 0);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(posedge clk); #1;
      seen = stream.out_valid && stream.out_chan == 4'd1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach_ch1: not presenting ch1 after budget"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({trigger_out, read_request, spi_done, stream.out_valid, stream.out_data, stream.out_chan,
         stream.out_first, stream.out_last, busy, trig_dropped, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b rr=%b valid=%b chan=%0d data=%h, all required 0",
               busy, read_request, stream.out_valid, stream.out_chan, stream.out_data);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    start_event(4'b1111, 2, 0);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done: busy still 1 after budget, want 0"); end
    bad = word_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_words: %0d mismatching words, want 0", bad); end
    checks++;
    if (first_valid_cyc - trig_cyc < HOLDOFF + 2 + SETTLE) begin
      errors++; $display("FAIL rstmid_holdoff: %0d cycles, want >= %0d", first_valid_cyc - trig_cyc, HOLDOFF + 2 + SETTLE);
    end
  endtask

  task automatic test_empty();
    bit ok;
    logic [NCH-1:0] masks [2];
    int             hms [2];
    masks[0] = 4'b1111; hms[0] = 0;
    masks[1] = 4'b0000; hms[1] = 3;
    for (int t = 0; t < 2; t++) begin
      start_event(masks[t], hms[t], 0);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL empty%0d_done: busy still 1 after budget", t); end
      checks++;
      if (busy_cycles !== HOLDOFF + NCH + 2) begin
        errors++; $display("FAIL empty%0d_busy: %0d cycles, want %0d", t, busy_cycles, HOLDOFF + NCH + 2);
      end
      checks++; if (n_valid !== 0) begin errors++; $display("FAIL empty%0d_valid: %0d valid cycles, want 0", t, n_valid); end
      checks++; if (n_trig_out !== 1) begin errors++; $display("FAIL empty%0d_trigger_out: %0d, want 1", t, n_trig_out); end
    end
  endtask

  task automatic test_random();
    bit ok; int bad, hm;
    logic [NCH-1:0] m;
    for (int t = 0; t < 6; t++) begin
      m  = NCH'($urandom);
      hm = $urandom_range(0, 4);
      start_event(m, hm, 2);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: busy still 1 after budget", t); end
      bad = word_mismatches();
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL rand%0d_words: mask=%b hm=%0d %0d mismatching, want 0", t, m, hm, bad);
      end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (n_spi[c] !== (m[c] ? hm : 0)) begin
          errors++; $display("FAIL rand%0d_spi ch%0d: %0d, want %0d", t, c, n_spi[c], m[c] ? hm : 0);
        end
      end
      checks++;
      if (viol_onehot !== 0 || viol_overlap !== 0 || viol_stall !== 0) begin
        errors++; $display("FAIL rand%0d_invariants: onehot=%0d overlap=%0d stall=%0d, want 0", t, viol_onehot, viol_overlap, viol_stall);
      end
    end
  endtask

`ifdef READOUT_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int bad;
    dead_mask = 4'b0100;
    start_event(4'b1111, 2, 0);
    build_model(4'b1011, 2);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_done: busy still 1 after budget"); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: timeout_err=%b, want 1", timeout_err); end
    checks++;
    if (terr_cyc - rr2_cyc !== TIMEOUT) begin
      errors++; $display("FAIL to_latency: %0d cycles, want %0d", terr_cyc - rr2_cyc, TIMEOUT);
    end
    bad = word_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_words: %0d mismatching words, want 0", bad); end
    dead_mask = '0;
    start_event(4'b0001, 1, 0);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: timeout_err=%b, want 0", timeout_err); end
    wait_idle(ok);
  endtask
`endif

  initial begin
    clear_mon();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_full_readout();
    test_mask_stall();
    test_drop();
    test_reset_mid();
    test_empty();
    test_random();
`ifdef READOUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
